uart_rx_fifo: RTL

- Receive buffer directly downstream of the UART receiver.
- Captures each byte presented with the receiver's one-cycle done tick and holds it in a circular buffer until the PicoBlaze port-read logic pops it.
- Decouples bursty serial arrivals from software polling, and flags lost bytes with a sticky overrun bit.

---
 rtl/uart_rx_fifo.sv | 95 +++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART receiver and the PicoBlaze port-read logic, with a sticky overrun flag.
// Optional: define UART_RX_FIFO_ALMOST_FULL_EN to add a registered almost_full output.
module uart_rx_fifo #(
  parameter int DBIT     = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_tick,
  input  logic [DBIT-1:0]   wr_data,
  input  logic              rd,
  input  logic              clr_overrun,
  output logic [DBIT-1:0]   rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  ,
  output logic              almost_full
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

  logic [DBIT-1:0]   r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overrun;

  logic              w_do_rd;
  logic              w_do_wr;
  logic              w_drop;
  logic [ADDR_W:0]   w_count_next;

  assign empty   = (r_count == '0);
  assign full    = (r_count == FULL_COUNT);
  assign count   = r_count;
  assign overrun = r_overrun;
  assign rd_data = r_mem[r_rd_ptr];

  // A pop while full frees a slot, so a write in the same cycle is accepted.
  assign w_do_rd      = rd & ~empty;
  assign w_do_wr      = wr_tick & (~full | w_do_rd);
  assign w_drop       = wr_tick & full & ~rd;
  assign w_count_next = r_count + (ADDR_W+1)'(w_do_wr) - (ADDR_W+1)'(w_do_rd);

  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      r_count <= w_count_next;
      // A dropped byte outranks a simultaneous clear.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clr_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  localparam logic [ADDR_W:0] AF_COUNT = (ADDR_W+1)'(AF_LEVEL);
  logic r_almost_full;

  assign almost_full = r_almost_full;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= (w_count_next >= AF_COUNT);
    end
  end
`endif

endmodule
